// File: rtl/wrapper_arbiter_pkg.sv
// Shared constants for the wrapper arbiter: FSM state codes, the "no grant"
// index, the default watchdog limit and a small index-to-one-hot helper.
package wrapper_arbiter_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_GRANT = 3'd1;
    localparam logic [2:0] ST_START = 3'd2;
    localparam logic [2:0] ST_WLOW  = 3'd3;
    localparam logic [2:0] ST_WHIGH = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;
    localparam logic [2:0] ST_ERR   = 3'd6;

    localparam logic [1:0] IDX_NONE    = 2'd3;
    localparam logic [7:0] TMO_DEFAULT = 8'd200;

    // Convert a requester index to a one-hot vector; IDX_NONE maps to zero.
    function automatic logic [2:0] idx_to_onehot(input logic [1:0] idx);
        logic [2:0] oh;
        case (idx)
            2'd0:    oh = 3'b001;
            2'd1:    oh = 3'b010;
            2'd2:    oh = 3'b100;
            default: oh = 3'b000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/wrapper_arbiter_cnt.sv
// 8-bit up counter with synchronous clear and count enable, used as the
// per-job watchdog. Clear has priority over enable.
module wrapper_arbiter_cnt (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    output logic [7:0] q
);

    logic [7:0] cnt_d;
    logic [7:0] cnt_q;

    // Next count value: clear, increment or hold.
    always_comb begin
        if (clr) begin
            cnt_d = 8'd0;
        end else if (en) begin
            cnt_d = cnt_q + 8'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register, asynchronously cleared by the active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign q = cnt_q;

endmodule

// File: rtl/wrapper_arbiter_rr_pick.sv
// Rotating-priority picker for three requesters. The search starts at the
// requester after ptr and wraps; purely combinational.
module rr_pick
    import wrapper_arbiter_pkg::*;
(
    input  logic [2:0] req,
    input  logic [1:0] ptr,
    output logic       valid,
    output logic [1:0] idx
);

    logic [1:0] first_s;
    logic [2:0] cand_s;

    // Walk the three candidates in priority order, keep the first that requests.
    always_comb begin
        valid  = 1'b0;
        idx    = IDX_NONE;
        cand_s = 3'd0;
        if (ptr >= 2'd2) begin
            first_s = 2'd0;
        end else begin
            first_s = ptr + 2'd1;
        end
        for (int k = 0; k < 3; k++) begin
            cand_s = {1'b0, first_s} + k[2:0];
            if (cand_s >= 3'd3) begin
                cand_s = cand_s - 3'd3;
            end else begin
                cand_s = cand_s;
            end
            if (!valid && req[cand_s[1:0]]) begin
                valid = 1'b1;
                idx   = cand_s[1:0];
            end else begin
                valid = valid;
            end
        end
    end

endmodule

// File: rtl/wrapper_arbiter.sv
// Three-requester arbiter for a shared wrapper engine. Grants one job at a
// time with rotating priority, starts the wrapper, tracks its wDone
// handshake and falls into an error state if the job overruns TMO cycles.
module wrapper_arbiter
    import wrapper_arbiter_pkg::*;
#(
    parameter logic [7:0] TMO = TMO_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] req,
    input  logic       wDone,
    input  logic       clr_err,
    output logic       wstart,
    output logic [2:0] gnt,
    output logic [1:0] sel,
    output logic [2:0] done,
    output logic       busy,
    output logic       err
);

    logic [2:0] state_d, state_q;
    logic [1:0] ptr_d,   ptr_q;
    logic [1:0] win_d,   win_q;

    logic       pick_valid_s;
    logic [1:0] pick_idx_s;
    logic [7:0] wdog_s;
    logic       wdog_clr_s;
    logic       wdog_en_s;
    logic       tmo_hit_s;

    rr_pick u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .valid (pick_valid_s),
        .idx   (pick_idx_s)
    );

    wrapper_arbiter_cnt u_wdog (
        .clk (clk),
        .rst (rst),
        .clr (wdog_clr_s),
        .en  (wdog_en_s),
        .q   (wdog_s)
    );

    // Watchdog is cleared in START so it reads zero on the first WLOW cycle;
    // the last counting cycle is TMO-1, so ERR is entered TMO cycles after WLOW.
    assign wdog_clr_s = (state_q == ST_START);
    assign wdog_en_s  = (state_q == ST_WLOW) || (state_q == ST_WHIGH);
    assign tmo_hit_s  = (wdog_s == (TMO - 8'd1));

    // Next-state, winner capture and priority pointer update.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        case (state_q)
            ST_IDLE: begin
                if ((req != 3'b000) && wDone && pick_valid_s) begin
                    state_d = ST_GRANT;
                    win_d   = pick_idx_s;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GRANT: state_d = ST_START;
            ST_START: state_d = ST_WLOW;
            ST_WLOW: begin
                if (tmo_hit_s) begin
                    state_d = ST_ERR;
                end else if (!wDone) begin
                    state_d = ST_WHIGH;
                end else begin
                    state_d = ST_WLOW;
                end
            end
            ST_WHIGH: begin
                if (tmo_hit_s) begin
                    state_d = ST_ERR;
                end else if (wDone) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_WHIGH;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                ptr_d   = win_q;
            end
            ST_ERR: begin
                if (clr_err) begin
                    state_d = ST_IDLE;
                    ptr_d   = win_q;
                end else begin
                    state_d = ST_ERR;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, pointer and winner registers; ptr resets to 2 so requester 0 wins first.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= 2'd2;
            win_q   <= IDX_NONE;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
        end
    end

    // Moore output decode from the state and registered winner only.
    always_comb begin
        wstart = 1'b0;
        gnt    = 3'b000;
        sel    = IDX_NONE;
        done   = 3'b000;
        busy   = 1'b1;
        err    = 1'b0;
        case (state_q)
            ST_IDLE: busy = 1'b0;
            ST_GRANT, ST_WLOW, ST_WHIGH: begin
                gnt = idx_to_onehot(win_q);
                sel = win_q;
            end
            ST_START: begin
                gnt    = idx_to_onehot(win_q);
                sel    = win_q;
                wstart = 1'b1;
            end
            ST_DONE: begin
                gnt  = idx_to_onehot(win_q);
                sel  = win_q;
                done = idx_to_onehot(win_q);
            end
            ST_ERR: begin
                gnt = idx_to_onehot(win_q);
                sel = win_q;
                err = 1'b1;
            end
            default: busy = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_wrapper_arbiter.sv
// Self-checking bench for wrapper_arbiter. A job-level reference model
// (rotating pointer plus modular search) predicts the winner; the bench plays
// the wrapper by driving wDone and checks every output on every cycle.
module tb_wrapper_arbiter;

    logic       clk;
    logic       rst;
    logic [2:0] req;
    logic       wDone;
    logic       clr_err;
    logic       wstart;
    logic [2:0] gnt;
    logic [1:0] sel;
    logic [2:0] done;
    logic       busy;
    logic       err;

    int vectors;
    int miscompares;
    int m_ptr;

    wrapper_arbiter #(.TMO(8'd20)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .wDone   (wDone),
        .clr_err (clr_err),
        .wstart  (wstart),
        .gnt     (gnt),
        .sel     (sel),
        .done    (done),
        .busy    (busy),
        .err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    // Winner = first requesting index scanning (ptr+1), (ptr+2), (ptr+3) mod 3.
    function automatic int model_pick(input logic [2:0] r, input int p);
        for (int k = 1; k <= 3; k++) begin
            int c;
            c = (p + k) % 3;
            if (r[c]) return c;
        end
        return 3;
    endfunction

    function automatic logic [2:0] oh(input int w);
        if (w < 3) return 3'b001 << w;
        return 3'b000;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [2:0] eg, input logic [1:0] es,
                       input logic ew, input logic [2:0] ed, input logic eb, input logic ee);
        logic [10:0] obs;
        logic [10:0] expv;
        obs  = {gnt, sel, wstart, done, busy, err};
        expv = {eg, es, ew, ed, eb, ee};
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed {gnt,sel,wstart,done,busy,err}=%b expected=%b", tag, obs, expv);
        end
    endtask

    // One complete job: pre = cycles wrapper stays idle after start,
    // lat = cycles wDone is low, drop = release the request during WLOW.
    task automatic do_job(input logic [2:0] r, input int pre, input int lat, input bit drop);
        int w;
        logic [2:0] g;
        logic [1:0] s;
        req = r;
        w = model_pick(r, m_ptr);
        g = oh(w);
        s = w[1:0];
        step(); chk("grant", g, s, 1'b0, 3'b000, 1'b1, 1'b0);
        step(); chk("start", g, s, 1'b1, 3'b000, 1'b1, 1'b0);
        step(); chk("wlow",  g, s, 1'b0, 3'b000, 1'b1, 1'b0);
        if (drop) req[w] = 1'b0;
        for (int i = 0; i < pre; i++) begin
            step(); chk("wlow_wait", g, s, 1'b0, 3'b000, 1'b1, 1'b0);
        end
        wDone = 1'b0;
        for (int i = 0; i < lat; i++) begin
            step(); chk("run", g, s, 1'b0, 3'b000, 1'b1, 1'b0);
        end
        wDone = 1'b1;
        step(); chk("done", g, s, 1'b0, g, 1'b1, 1'b0);
        m_ptr = w;
        step(); chk("idle_after", 3'b000, 2'd3, 1'b0, 3'b000, 1'b0, 1'b0);
    endtask

    // Job whose wrapper never leaves idle: ERR exactly 20 cycles after WLOW entry.
    task automatic tmo_job(input logic [2:0] r);
        int w;
        logic [2:0] g;
        logic [1:0] s;
        req = r;
        w = model_pick(r, m_ptr);
        g = oh(w);
        s = w[1:0];
        step(); chk("tmo_grant", g, s, 1'b0, 3'b000, 1'b1, 1'b0);
        step(); chk("tmo_start", g, s, 1'b1, 3'b000, 1'b1, 1'b0);
        step(); chk("tmo_wlow",  g, s, 1'b0, 3'b000, 1'b1, 1'b0);
        for (int k = 1; k < 20; k++) begin
            step(); chk("tmo_wait", g, s, 1'b0, 3'b000, 1'b1, 1'b0);
        end
        step(); chk("tmo_err", g, s, 1'b0, 3'b000, 1'b1, 1'b1);
        step(); chk("tmo_err_hold", g, s, 1'b0, 3'b000, 1'b1, 1'b1);
        clr_err = 1'b1;
        step(); chk("tmo_clr", 3'b000, 2'd3, 1'b0, 3'b000, 1'b0, 1'b0);
        clr_err = 1'b0;
        m_ptr = w;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        m_ptr       = 2;
        rst     = 1'b0;
        req     = 3'b000;
        wDone   = 1'b1;
        clr_err = 1'b0;
        #1;
        chk("reset", 3'b000, 2'd3, 1'b0, 3'b000, 1'b0, 1'b0);
        step();
        step();
        rst = 1'b1;
        step(); chk("idle_post_reset", 3'b000, 2'd3, 1'b0, 3'b000, 1'b0, 1'b0);

        // Single request, wrapper busy 10 cycles.
        do_job(3'b001, 0, 10, 1'b0);
        // Fairness after skip: ptr is 0, requester 2 beats 0.
        do_job(3'b101, 1, 3, 1'b0);
        // Contention with all held: 0,1,2,0.
        for (int j = 0; j < 4; j++) do_job(3'b111, 0, 2, 1'b0);
        // Request dropped during WLOW still completes.
        do_job(3'b010, 2, 4, 1'b1);
        // Timeout on requester 2, then it loses priority.
        tmo_job(3'b111);
        do_job(3'b111, 0, 3, 1'b0);

        // Wrapper externally busy holds the arbiter in IDLE.
        req   = 3'b001;
        wDone = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(); chk("idle_hold", 3'b000, 2'd3, 1'b0, 3'b000, 1'b0, 1'b0);
        end
        wDone = 1'b1;
        do_job(3'b001, 0, 2, 1'b0);

        // Reset in WHIGH abandons the job immediately.
        req = 3'b001;
        step(); chk("mr_grant", oh(model_pick(3'b001, m_ptr)), 2'd0, 1'b0, 3'b000, 1'b1, 1'b0);
        step();
        step();
        wDone = 1'b0;
        step();
        step();
        rst = 1'b0;
        #1;
        chk("reset_async", 3'b000, 2'd3, 1'b0, 3'b000, 1'b0, 1'b0);
        wDone = 1'b1;
        req   = 3'b000;
        step(); chk("reset_held", 3'b000, 2'd3, 1'b0, 3'b000, 1'b0, 1'b0);
        rst   = 1'b1;
        m_ptr = 2;
        step(); chk("reset_release", 3'b000, 2'd3, 1'b0, 3'b000, 1'b0, 1'b0);
        do_job(3'b010, 0, 3, 1'b0);

        // Randomized jobs against the reference model.
        for (int j = 0; j < 25; j++) begin
            logic [2:0] r;
            int pre;
            int lat;
            bit drop;
            r    = 3'($urandom_range(1, 7));
            pre  = int'($urandom_range(0, 4));
            lat  = int'($urandom_range(1, 10));
            drop = 1'($urandom_range(0, 1));
            do_job(r, pre, lat, drop);
        end

        req = 3'b000;
        step(); chk("final_idle", 3'b000, 2'd3, 1'b0, 3'b000, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
